neuron_param_loader: RTL and testbench

- Writer side of the neuron weight/bias load interface: turns a flat word stream (from the AXI/DMA front end) into per-neuron `weightValid`/`weightValue`/`biasValid`/`biasValue` strobes.
- Also drives the `config_layer_num`/`config_neuron_num` select buses that every neuron decodes.
- Sits between the stream front end and the neuron array. One instance feeds all neurons of all layers.

---
 rtl/neuron_param_loader_pkg.sv | 32 +++
 rtl/neuron_param_loader_if.sv | 13 +
 rtl/neuron_param_loader_ctrl.sv | 129 ++++++++++++
 rtl/neuron_param_loader.sv | 74 +++++++
 tb/tb_neuron_param_loader.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/neuron_param_loader_pkg.sv
// Shared constants and FSM encoding for the neuron parameter loader.
// Optional build macro: LOADER_CHECKSUM_EN adds the CHECK state.
`ifndef dataWidth
`define dataWidth 16
`endif

package neuron_param_loader_pkg;

  localparam int DATA_WIDTH  = `dataWidth;
  localparam int MAX_WEIGHTS = 128;
  localparam int CNT_W       = $clog2(MAX_WEIGHTS + 1);
  localparam int CFG_NUM_W   = 2 * DATA_WIDTH + 1;

  // Position of each header word within a record
  localparam int HDR_LAYER_IDX  = 0;
  localparam int HDR_NEURON_IDX = 1;
  localparam int HDR_COUNT_IDX  = 2;

  // Header states share their encoding with the header word index
  typedef enum logic [2:0] {
    H_LAYER  = 3'(HDR_LAYER_IDX),
    H_NEURON = 3'(HDR_NEURON_IDX),
    H_COUNT  = 3'(HDR_COUNT_IDX),
    WEIGHTS  = 3'd3,
    BIAS     = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    CHECK    = 3'd5,
`endif
    ERR      = 3'd6
  } state_e;

endpackage

// File: rtl/neuron_param_loader_if.sv
// Word stream handshake feeding the neuron parameter loader.
// Optional build macro: LOADER_CHECKSUM_EN (no effect on this interface).
interface neuron_param_loader_if;
  import neuron_param_loader_pkg::*;

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/neuron_param_loader_ctrl.sv
// Record-parsing FSM and weight down-counter for the parameter loader.
// Emits single-cycle combinational strobes on each accepted word; the top
// registers them. Optional build macro: LOADER_CHECKSUM_EN adds a trailing
// checksum word and the CHECK state.
module neuron_param_loader_ctrl
  import neuron_param_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  ld_layer_o,
  output logic                  ld_neuron_o,
  output logic                  wt_stb_o,
  output logic                  bias_stb_o,
  output logic                  done_stb_o,
  output logic                  err_stb_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q;
  logic             accept;
  logic             count_ok;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  assign accept   = valid_i & ready_q;
  assign count_ok = (data_i != '0) && (data_i <= DATA_WIDTH'(MAX_WEIGHTS));
  assign ready_o  = ready_q;

  // State, counter and registered ready; ready tracks the state being entered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= H_LAYER;
      cnt_q   <= '0;
      ready_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d != ERR);
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Next state: advance only on an accepted word
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (accept) begin
      case (state_q)
        H_LAYER:  state_d = H_NEURON;
        H_NEURON: state_d = H_COUNT;
        H_COUNT: begin
          if (count_ok) begin
            state_d = WEIGHTS;
            cnt_d   = CNT_W'(data_i);
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else begin
            state_d = ERR;
          end
        end
        WEIGHTS: begin
          cnt_d = cnt_q - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + data_i;
`endif
          if (cnt_q == CNT_W'(1)) state_d = BIAS;
        end
        BIAS: begin
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + data_i;
          state_d = CHECK;
`else
          state_d = H_LAYER;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK:    state_d = (data_i == sum_q) ? H_LAYER : ERR;
`endif
        default:  state_d = state_q;
      endcase
    end
  end

  // Output strobes for the word being accepted this cycle
  always_comb begin
    ld_layer_o  = 1'b0;
    ld_neuron_o = 1'b0;
    wt_stb_o    = 1'b0;
    bias_stb_o  = 1'b0;
    done_stb_o  = 1'b0;
    err_stb_o   = 1'b0;
    if (accept) begin
      case (state_q)
        H_LAYER:  ld_layer_o  = 1'b1;
        H_NEURON: ld_neuron_o = 1'b1;
        H_COUNT:  err_stb_o   = !count_ok;
        WEIGHTS:  wt_stb_o    = 1'b1;
        BIAS: begin
          bias_stb_o = 1'b1;
`ifndef LOADER_CHECKSUM_EN
          done_stb_o = 1'b1;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          done_stb_o = (data_i == sum_q);
          err_stb_o  = (data_i != sum_q);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/neuron_param_loader.sv
// Neuron weight/bias loader: converts a flat word stream into per-neuron
// weight/bias strobes and drives the layer/neuron select buses.
// Optional build macro: LOADER_CHECKSUM_EN (trailing checksum word per record).
module neuron_param_loader
  import neuron_param_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  neuron_param_loader_if.slave  s,
  output logic                  weightValid,
  output logic [DATA_WIDTH-1:0] weightValue,
  output logic                  biasValid,
  output logic [DATA_WIDTH-1:0] biasValue,
  output logic [CFG_NUM_W-1:0]  config_layer_num,
  output logic [CFG_NUM_W-1:0]  config_neuron_num,
  output logic                  rec_done,
  output logic                  err
);

  logic ready;
  logic ld_layer, ld_neuron, wt_stb, bias_stb, done_stb, err_stb;

  logic                  weight_valid_q, bias_valid_q, rec_done_q, err_q;
  logic [DATA_WIDTH-1:0] weight_value_q, bias_value_q;
  logic [CFG_NUM_W-1:0]  layer_q, neuron_q;

  neuron_param_loader_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .data_i      (s.s_data),
    .valid_i     (s.s_valid),
    .ready_o     (ready),
    .ld_layer_o  (ld_layer),
    .ld_neuron_o (ld_neuron),
    .wt_stb_o    (wt_stb),
    .bias_stb_o  (bias_stb),
    .done_stb_o  (done_stb),
    .err_stb_o   (err_stb)
  );

  // Strobe, value and select registers; selects hold until the next header
  always_ff @(posedge clk) begin
    if (!rst) begin
      weight_valid_q <= 1'b0;
      weight_value_q <= '0;
      bias_valid_q   <= 1'b0;
      bias_value_q   <= '0;
      layer_q        <= '0;
      neuron_q       <= '0;
      rec_done_q     <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      weight_valid_q <= wt_stb;
      bias_valid_q   <= bias_stb;
      rec_done_q     <= done_stb;
      err_q          <= err_q | err_stb;
      if (wt_stb)    weight_value_q <= s.s_data;
      if (bias_stb)  bias_value_q   <= s.s_data;
      if (ld_layer)  layer_q        <= CFG_NUM_W'(s.s_data);
      if (ld_neuron) neuron_q       <= CFG_NUM_W'(s.s_data);
    end
  end

  assign s.s_ready         = ready;
  assign weightValid       = weight_valid_q;
  assign weightValue       = weight_value_q;
  assign biasValid         = bias_valid_q;
  assign biasValue         = bias_value_q;
  assign config_layer_num  = layer_q;
  assign config_neuron_num = neuron_q;
  assign rec_done          = rec_done_q;
  assign err               = err_q;

endmodule

// File: tb/tb_neuron_param_loader.sv
// Directed bench for neuron_param_loader.
// Build with LOADER_CHECKSUM_EN defined to exercise the checksum variant.
module tb_neuron_param_loader;
  import neuron_param_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic                  weightValid, biasValid, rec_done, err;
  logic [DATA_WIDTH-1:0] weightValue, biasValue;
  logic [CFG_NUM_W-1:0]  config_layer_num, config_neuron_num;

  neuron_param_loader_if bus ();

  neuron_param_loader dut (
    .clk               (clk),
    .rst               (rst),
    .s                 (bus),
    .weightValid       (weightValid),
    .weightValue       (weightValue),
    .biasValid         (biasValid),
    .biasValue         (biasValue),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .rec_done          (rec_done),
    .err               (err)
  );

  always #5 clk = ~clk;

`ifdef LOADER_CHECKSUM_EN
  localparam logic DONE_AT_BIAS = 1'b0;
`else
  localparam logic DONE_AT_BIAS = 1'b1;
`endif

  int total = 0;
  int bad   = 0;
  int wcnt  = 0;
  logic [15:0] wq[$];
  logic [15:0] last_neu = 16'h0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive just after a falling edge, sample at the next falling edge
  task automatic cyc(input logic v, input logic [15:0] d,
                     input logic ew, input logic eb, input logic ed, input string tag);
    bus.s_valid = v;
    bus.s_data  = d;
    @(negedge clk);
    if (weightValid) wcnt++;
    chk_eq({tag, "_wv"}, weightValid, ew);
    chk_eq({tag, "_bv"}, biasValid, eb);
    chk_eq({tag, "_done"}, rec_done, ed);
    if (ew) chk_eq({tag, "_wval"}, weightValue, d);
    if (eb) chk_eq({tag, "_bval"}, biasValue, d);
  endtask

  task automatic gap(input int n);
    for (int g = 0; g < n; g++) cyc(1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, "gap");
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0030;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      chk_eq("rst_ready", bus.s_ready, 1'b0);
      chk_eq("rst_outs", {weightValid, biasValid, rec_done, err}, 4'b0);
      chk_eq("rst_vals", {weightValue, biasValue}, 32'h0);
      chk_eq("rst_sel", {config_layer_num, config_neuron_num}, 66'h0);
    end
    rst = 1'b1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk_eq("rel_ready", bus.s_ready, 1'b1);
    chk_eq("rel_err", err, 1'b0);
    last_neu = 16'h0;
  endtask

  // Sends one complete record built from wq, with n idle cycles after each word
  task automatic run_record(input logic [15:0] lay, input logic [15:0] neu,
                            input logic [15:0] bias, input int n);
    logic [15:0] sum;
    sum = 16'h0;
    cyc(1'b1, lay, 1'b0, 1'b0, 1'b0, "hdr_l");
    chk_eq("sel_layer", config_layer_num, {17'h0, lay});
    chk_eq("sel_neu_hold", config_neuron_num, {17'h0, last_neu});
    gap(n);
    cyc(1'b1, neu, 1'b0, 1'b0, 1'b0, "hdr_n");
    chk_eq("sel_neuron", config_neuron_num, {17'h0, neu});
    gap(n);
    cyc(1'b1, 16'(wq.size()), 1'b0, 1'b0, 1'b0, "hdr_c");
    gap(n);
    foreach (wq[i]) begin
      cyc(1'b1, wq[i], 1'b1, 1'b0, 1'b0, "wt");
      chk_eq("sel_hold", {config_layer_num, config_neuron_num}, {17'h0, lay, 17'h0, neu});
      sum = sum + wq[i];
      gap(n);
    end
    cyc(1'b1, bias, 1'b0, 1'b1, DONE_AT_BIAS, "bias");
    sum = sum + bias;
    gap(n);
`ifdef LOADER_CHECKSUM_EN
    cyc(1'b1, sum, 1'b0, 1'b0, 1'b1, "csum");
    gap(n);
`endif
    chk_eq("rec_err", err, 1'b0);
    chk_eq("rec_sel", {config_layer_num, config_neuron_num}, {17'h0, lay, 17'h0, neu});
    last_neu = neu;
  endtask

  task automatic bad_count(input logic [15:0] n);
    cyc(1'b1, 16'd1, 1'b0, 1'b0, 1'b0, "bc_l");
    cyc(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, "bc_n");
    cyc(1'b1, n,     1'b0, 1'b0, 1'b0, "bc_c");
    chk_eq("bc_err", err, 1'b1);
    chk_eq("bc_ready", bus.s_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, "bc_stuck");
      chk_eq("bc_err_hold", err, 1'b1);
      chk_eq("bc_ready_hold", bus.s_ready, 1'b0);
    end
  endtask

  initial begin
    int w0;
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 16'h0;
    @(negedge clk);
    do_reset();

    // Basic record, continuous valid
    wq = '{16'h0010, 16'h0020, 16'h0030};
    run_record(16'd1, 16'd5, 16'hFFF0, 0);
    gap(2);
    chk_eq("idle_sel", {config_layer_num, config_neuron_num}, {17'h0, 16'd1, 17'h0, 16'd5});

    // Same record with two idle cycles between words
    run_record(16'd1, 16'd5, 16'hFFF0, 2);

    // Illegal counts: zero, then one past the maximum
    do_reset();
    bad_count(16'd0);
    do_reset();
    bad_count(16'd129);
    do_reset();

    // Largest legal record, then a second record with no gap
    wq.delete();
    for (int i = 0; i < 128; i++) wq.push_back(16'(i * 3 + 1));
    w0 = wcnt;
    run_record(16'd1, 16'd5, 16'h00AA, 0);
    wq = '{16'h0001};
    run_record(16'd2, 16'd7, 16'h0002, 0);
    chk_eq("wt_pulses", 32'(wcnt - w0), 32'd129);

    // Reset partway through a record, then a fresh record
    cyc(1'b1, 16'd1,    1'b0, 1'b0, 1'b0, "mr_l");
    cyc(1'b1, 16'd5,    1'b0, 1'b0, 1'b0, "mr_n");
    cyc(1'b1, 16'd3,    1'b0, 1'b0, 1'b0, "mr_c");
    cyc(1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, "mr_w0");
    cyc(1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, "mr_w1");
    do_reset();
    wq = '{16'h000A, 16'h000B};
    run_record(16'd4, 16'd9, 16'h000C, 0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match, then mismatch
    do_reset();
    cyc(1'b1, 16'd1,    1'b0, 1'b0, 1'b0, "ck_l");
    cyc(1'b1, 16'd5,    1'b0, 1'b0, 1'b0, "ck_n");
    cyc(1'b1, 16'd2,    1'b0, 1'b0, 1'b0, "ck_c");
    cyc(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, "ck_w0");
    cyc(1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, "ck_w1");
    cyc(1'b1, 16'h0005, 1'b0, 1'b1, 1'b0, "ck_b");
    cyc(1'b1, 16'h000C, 1'b0, 1'b0, 1'b1, "ck_ok");
    chk_eq("ck_ok_err", err, 1'b0);
    cyc(1'b1, 16'd1,    1'b0, 1'b0, 1'b0, "cx_l");
    cyc(1'b1, 16'd5,    1'b0, 1'b0, 1'b0, "cx_n");
    cyc(1'b1, 16'd2,    1'b0, 1'b0, 1'b0, "cx_c");
    cyc(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, "cx_w0");
    cyc(1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, "cx_w1");
    cyc(1'b1, 16'h0005, 1'b0, 1'b1, 1'b0, "cx_b");
    cyc(1'b1, 16'h000D, 1'b0, 1'b0, 1'b0, "cx_bad");
    chk_eq("cx_err", err, 1'b1);
    chk_eq("cx_ready", bus.s_ready, 1'b0);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
